// File: rtl/cla_slice_seq.sv
`default_nettype none
// ============================================================================
// Module   : cla_slice_seq
// Purpose  : Multi-cycle adder. It pushes a WIDTH-bit add through one
//            SLICE-bit slice per cycle and keeps the carry in a register.
//            Defining CLA_SLICE_SEQ_SUB_EN enables a - b on sub=1.
// Revision : 1.0 - initial release
// ============================================================================
module cla_slice_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_c_out;
  logic             r_out_valid;
  logic [CW-1:0]    r_cnt;

  logic [SLICE:0]   w_add;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

`ifdef CLA_SLICE_SEQ_SUB_EN
  // Two's-complement subtract: invert b and force the carry-in to one.
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : c_in;
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_load     = b;
  assign w_c_load     = c_in;
`endif

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == C_LAST);

  assign w_add = {1'b0, r_a_sh[SLICE-1:0]}
               + {1'b0, r_b_sh[SLICE-1:0]}
               + {{SLICE{1'b0}}, r_carry};

  // Each new slice goes in at the top. After N shifts the first slice sits at bit 0.
  assign w_res_next = (r_res >> SLICE)
                    | (WIDTH'(w_add[SLICE-1:0]) << (WIDTH - SLICE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_res       <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_c_out     <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_a_sh  <= a;
        r_b_sh  <= w_b_load;
        r_carry <= w_c_load;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a_sh  <= r_a_sh >> SLICE;
        r_b_sh  <= r_b_sh >> SLICE;
        r_res   <= w_res_next;
        r_carry <= w_add[SLICE];
        if (w_last) begin
          r_sum       <= w_res_next;
          r_c_out     <= w_add[SLICE];
          r_out_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if ((r_state == DONE) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;

endmodule
`default_nettype wire

// File: doc/cla_slice_seq.md
Name: cla_slice_seq

Overview:
- Multi-cycle adder controller: sequences a WIDTH-bit add through one narrow SLICE-bit carry-lookahead slice, SLICE bits per cycle, carry held in a register between slices.
- Sits in the CPU arithmetic path as an area-saving alternative to a full-width CLA tree.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 16, operand/result width; must be a positive multiple of SLICE.
- SLICE, 2, bits added per cycle (slice adder width). N = WIDTH/SLICE cycles per operation.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands; combinational, high only in IDLE.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- c_in  input  1  carry-in, sampled on accept.
- sub  input  1  subtract request, sampled on accept; used only when the optional feature is compiled in.
- out_valid  output  1  result available; registered.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result register.
- c_out  output  1  carry-out of the MSB slice.
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Reset state is IDLE. Reset values: out_valid=0, sum=0, c_out=0, busy=0, slice counter=0, carry register=0. in_ready=1 during and after reset.
- IDLE: in_ready=1. On in_valid&in_ready:
  - load working A/B shift registers from a/b.
  - load carry register from c_in.
  - clear counter.
  - go to RUN.
- RUN, one slice per cycle:
  - Compute {cy, s} = A_sh[SLICE-1:0] + B_sh[SLICE-1:0] + carry; the add is SLICE+1 bits wide.
  - Shift A_sh/B_sh right by SLICE.
  - Shift s into the MSB end of the working result register, so the result fills LSB-first and ends aligned after N shifts.
  - carry <= cy; counter++.
  - After the N-th slice, the counter has reached N-1 and increments no further. sum <= final working result, c_out <= final cy, out_valid <= 1, go to DONE.
- DONE: out_valid=1; sum and c_out stay stable. On out_ready: out_valid <= 0 and go to IDLE.
- sum and c_out update only on the RUN->DONE transition. They hold the last result otherwise, including in IDLE.
- Latency: operands accepted at edge k; out_valid high after edge k+N. Back-to-back throughput is one op per N+2 cycles when out_ready is held high.
- Operand inputs, c_in and sub are ignored outside the accept edge. Changes during RUN/DONE have no effect.
- in_valid in RUN/DONE is not accepted (in_ready=0). The requester must hold the request.
- WIDTH==SLICE: N=1; RUN lasts exactly one cycle.
- out_ready high while not in DONE: ignored.
- Carry propagates across all slices; e.g. an all-ones + 1 add ripples the carry through every slice via the carry register.
- Reset asserted mid-RUN or in DONE: immediate abort to reset values. No out_valid is produced for the aborted op. The next accepted op is unaffected.
- Counter width is clog2(N) bits, minimum 1. It never wraps during an operation.

Optional Feature:
- Macro CLA_SLICE_SEQ_SUB_EN.
- Defined:
  - On accept with sub=1, B_sh loads ~b and the carry register loads 1 (c_in ignored). Result is a-b mod 2^WIDTH.
  - c_out=1 means no borrow (a>=b unsigned).
  - sub=0 behaves as add.
- Undefined: sub is ignored; every op is a+b+c_in.
- Timing and handshake are identical in both builds.

Test Plan:
- WIDTH=16, SLICE=2: a=0x1234, b=0x4321, c_in=0 -> sum=0x5555, c_out=0; out_valid rises exactly 8 cycles after the accept edge.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1. Also a=0x7FFF, b=0x0000, c_in=1 -> sum=0x8000, c_out=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid with new operands:
  - sum and out_valid stay stable; in_ready=0; new operands are not taken.
  - After out_ready pulses, in_ready=1 the next cycle.
- Assert rst for 1 cycle during the 3rd RUN cycle:
  - Outputs take reset values immediately; out_valid never asserts for that op.
  - A following op a=0x00FF, b=0x0001 -> sum=0x0100, c_out=0.
- Back-to-back: out_ready tied high, in_valid held with 3 op sets -> results in order, one every 10 cycles.
- Feature on: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0. a=0x0007, b=0x0005, sub=1 -> sum=0x0002, c_out=1. Feature off, same first op -> sum=0x000C, c_out=0.
